pe_ws_acc: RTL
==============

Name: pe_ws_acc

Overview:
- Next-generation weight-stationary processing element for the systolic array.
- Generalises the basic PE with separate operand/accumulator widths and valid-tagged activation and partial-sum streams.
- Adds a double-buffered weight register (shadow chain plus active), so the next weight tile preloads while the current tile computes.
- Tiles in a ROWS x COLS grid:
  - activations flow left->right;
  - partial sums and weight chain flow top->bottom.

Parameters:
DATA_W, 8, activation/weight width, signed two's complement
ACC_W, 24, partial-sum width, signed; must be >= 2*DATA_W (elaboration-time assertion)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
w_in  in  DATA_W  weight shift-chain input from PE above
w_load  in  1  shift enable for weight chain
w_out  out  DATA_W  shadow weight to PE below (chain)
w_load_out  out  1  w_load registered, to PE below
w_swap  in  1  commit shadow->active weight (pulse)
w_swap_out  out  1  w_swap registered, to PE right (skewed commit wavefront)
act_in  in  DATA_W  activation from left
act_valid_in  in  1  activation valid
act_out  out  DATA_W  activation to right, registered
act_valid_out  out  1  registered act_valid_in
psum_in  in  ACC_W  partial sum from above
psum_valid_in  in  1  partial-sum valid
psum_out  out  ACC_W  partial sum to below, registered
psum_valid_out  out  1  registered result valid
err  out  1  sticky valid-misalignment flag

Behaviour:
- Reset (rst=1, async): all registers and outputs clear to 0, including shadow_w, active_w, act_out, psum_out, all valid/pulse outputs, and err.
- Weight chain:
  - When w_load=1, shadow_w <= w_in at the clock edge.
  - w_out = shadow_w (registered).
  - w_load_out <= w_load.
  - A column of N PEs therefore loads in N cycles; the bottom PE's value enters first.
- Swap:
  - When w_swap=1, active_w <= shadow_w at the clock edge.
  - The new weight is used from the next cycle's MAC onward.
  - w_swap_out <= w_swap.
- Simultaneous w_load and w_swap: active_w takes the pre-shift shadow_w; the shift still occurs.
- Activation pass-through, every cycle regardless of valid:
  - act_out <= act_in;
  - act_valid_out <= act_valid_in.
  - Latency: 1 cycle.
- MAC:
  - prod = act_in * active_w, full 2*DATA_W signed.
  - prod is sign-extended to ACC_W.
  - sum = psum_in + prod, computed at ACC_W+1 bits.
- Result update:
  - If act_valid_in && psum_valid_in: psum_out <= sum reduced to ACC_W (see Optional Feature); psum_valid_out <= 1.
  - If neither valid: psum_out holds its value; psum_valid_out <= 0.
  - If exactly one valid: err <= 1; psum_out holds; psum_valid_out <= 0.
- err is sticky; only rst clears it.
- Latency: psum_in to psum_out is 1 cycle.
- A valid activation seen on cycle t reaches the right neighbour on t+1, giving the standard skewed schedule.
- Reset mid-operation: all in-flight results are discarded, and both weights return to 0; the weights must be reloaded.
- No back-pressure: the array is free-running, and upstream guarantees skew alignment.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined: on overflow, psum_out saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) based on the ACC_W+1-bit sum sign/overflow.
- Added output sat_flag (1 bit): registered, high for the cycle whose result saturated; reset 0.
- Undefined: psum_out = low ACC_W bits of the sum (two's-complement wrap); port sat_flag is absent.

Test Plan:
1. Reset values:
   - Stimulus: assert rst asynchronously mid-cycle with all inputs toggling.
   - Response: all outputs 0 immediately.
   - After deassert and a valid MAC, err stays 0.
2. Load, swap, MAC:
   - Stimulus: w_load=1 with w_in=5 for 1 cycle, then w_swap pulse, then act=3 and psum=10, both valid.
   - Response: psum_out=25, psum_valid_out=1 one cycle after the operands; w_swap_out pulses one cycle after w_swap.
3. Preload during compute:
   - Stimulus: active_w=2; stream act=1,2,3 with psum=0, all valid, while loading shadow_w=-4; swap after the 3rd operand, then act=1.
   - Response: psum_out sequence 2, 4, 6, then -4.
4. Simultaneous load and swap:
   - Stimulus: shadow_w=7; same cycle w_load=1, w_in=9, w_swap=1.
   - Response: active_w=7, shadow_w=9, w_out=9.
5. Misalignment:
   - Stimulus: act_valid_in=1 with psum_valid_in=0.
   - Response: err=1 and remains 1 after further valid traffic; psum_valid_out=0 on that cycle.
6. Overflow, DATA_W=8, ACC_W=16:
   - Stimulus: psum_in=32000, act=127, w=127 (sum 48129).
   - With PE_ACC_SAT_EN: psum_out=32767, sat_flag=1.
   - Without: psum_out=-17407.

Source files
------------

// File: rtl/pe_ws_acc.sv
// pe_ws_acc: weight-stationary systolic PE.
// It has a double-buffered weight, valid-tagged operands and a sticky
// misalignment error flag.
//
// Ports:
//   clk, rst        : clock and async active-high reset
//   w_in/w_load     : weight shift chain in (from PE above)
//   w_out/w_load_out: shadow weight and load, registered (to PE below)
//   w_swap          : commit shadow weight to active weight
//   w_swap_out      : w_swap registered (to PE right)
//   act_in/_valid_in: activation from the left
//   act_out/_valid_out: activation to the right, 1-cycle latency
//   psum_in/_valid_in : partial sum from above
//   psum_out/_valid_out: psum_in + act_in*active_w, registered
//   err             : sticky flag, set when exactly one operand is valid
//   sat_flag        : result saturated this cycle (PE_ACC_SAT_EN only)
//
// Build option: define PE_ACC_SAT_EN to saturate on accumulator
// overflow. Without it, the result wraps.
module pe_ws_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    output logic [DATA_W-1:0] w_out,
    output logic              w_load_out,
    input  logic              w_swap,
    output logic              w_swap_out,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_valid_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_valid_out,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_valid_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    output logic              err
`ifdef PE_ACC_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
        $error("pe_ws_acc: ACC_W must be >= 2*DATA_W");
    end

    localparam int PW = 2*DATA_W;

    logic [DATA_W-1:0] r_shadow_w;
    logic [DATA_W-1:0] r_active_w;
    logic              r_w_load;
    logic              r_w_swap;
    logic [DATA_W-1:0] r_act;
    logic              r_act_v;
    logic [ACC_W-1:0]  r_psum;
    logic              r_psum_v;
    logic              r_err;

    logic [PW-1:0]     w_act_x;
    logic [PW-1:0]     w_wt_x;
    logic [PW-1:0]     w_prod;
    logic [ACC_W:0]    w_prod_x;
    logic [ACC_W:0]    w_psum_x;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  w_res;
    logic              w_both;
    logic              w_one;

    // Sign-extending both operands to the product width first means
    // that the low PW bits of the product are the exact signed product.
    assign w_act_x  = {{DATA_W{act_in[DATA_W-1]}}, act_in};
    assign w_wt_x   = {{DATA_W{r_active_w[DATA_W-1]}}, r_active_w};
    assign w_prod   = w_act_x * w_wt_x;
    assign w_prod_x = {{(ACC_W+1-PW){w_prod[PW-1]}}, w_prod};
    assign w_psum_x = {psum_in[ACC_W-1], psum_in};
    assign w_sum    = w_psum_x + w_prod_x;

    assign w_both = act_valid_in & psum_valid_in;
    assign w_one  = act_valid_in ^ psum_valid_in;

`ifdef PE_ACC_SAT_EN
    logic w_ovf;
    logic r_sat;

    // The sum overflows when the extra sign bit disagrees with bit ACC_W-1.
    assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_res = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            if (w_sum[ACC_W])
                w_res = {1'b1, {(ACC_W-1){1'b0}}};
            else
                w_res = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat <= 1'b0;
        else
            r_sat <= w_both & w_ovf;
    end

    assign sat_flag = r_sat;
`else
    logic w_unused_sign;

    assign w_unused_sign = w_sum[ACC_W];
    assign w_res         = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_w <= '0;
            r_active_w <= '0;
            r_w_load   <= 1'b0;
            r_w_swap   <= 1'b0;
            r_act      <= '0;
            r_act_v    <= 1'b0;
            r_psum     <= '0;
            r_psum_v   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // With load and swap in the same cycle, the swap commits
            // the pre-shift shadow value.
            if (w_load)
                r_shadow_w <= w_in;
            if (w_swap)
                r_active_w <= r_shadow_w;
            r_w_load <= w_load;
            r_w_swap <= w_swap;
            r_act    <= act_in;
            r_act_v  <= act_valid_in;
            r_psum_v <= w_both;
            if (w_both)
                r_psum <= w_res;
            if (w_one)
                r_err <= 1'b1;
        end
    end

    assign w_out          = r_shadow_w;
    assign w_load_out     = r_w_load;
    assign w_swap_out     = r_w_swap;
    assign act_out        = r_act;
    assign act_valid_out  = r_act_v;
    assign psum_out       = r_psum;
    assign psum_valid_out = r_psum_v;
    assign err            = r_err;

endmodule
